// File: rtl/mxint_cast_arb_pkg.sv
// Shared types and constants for the MXINT cast arbiter and its tag FIFO.
// Optional statistics counters are enabled with MXINT_CAST_ARB_STATS_EN.
package mxint_cast_arb_pkg;

  localparam int DEF_NUM_REQ         = 4;
  localparam int DEF_MAX_OUTSTANDING = 4;
  localparam int TAG_W               = $clog2(DEF_NUM_REQ);
  localparam int CNT_W               = $clog2(DEF_MAX_OUTSTANDING) + 1;
  localparam int STATS_W             = 16;
  localparam logic [STATS_W-1:0] STATS_MAX = 16'hFFFF;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Index width that stays legal when a dimension collapses to one entry.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == STATS_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mxint_arb_tag_fifo.sv
// Tag FIFO remembering which requester owns each block in flight.
// DEPTH must be a power of two so the pointers wrap naturally.
module mxint_arb_tag_fifo
  import mxint_cast_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = idx_w(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign head      = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage, pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mxint_cast_arbiter.sv
// Round-robin arbiter sharing one MXINT cast datapath among NUM_REQ requesters,
// with in-order result routing by tag. MXINT_CAST_ARB_STATS_EN adds grant_count.
module mxint_cast_arbiter
  import mxint_cast_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int IN_MAN_WIDTH    = 8,
  parameter int IN_EXP_WIDTH    = 4,
  parameter int OUT_MAN_WIDTH   = 8,
  parameter int OUT_EXP_WIDTH   = 4,
  parameter int BLOCK_SIZE      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_REQ*BLOCK_SIZE*IN_MAN_WIDTH-1:0] req_mdata_in,
  input  logic [NUM_REQ*IN_EXP_WIDTH-1:0]            req_edata_in,
  input  logic [NUM_REQ-1:0]                         req_valid,
  output logic [NUM_REQ-1:0]                         req_ready,
  output logic [BLOCK_SIZE*IN_MAN_WIDTH-1:0]         cast_mdata_out,
  output logic [IN_EXP_WIDTH-1:0]                    cast_edata_out,
  output logic                                       cast_valid,
  input  logic                                       cast_ready,
  input  logic [BLOCK_SIZE*OUT_MAN_WIDTH-1:0]        cast_mdata_in,
  input  logic [OUT_EXP_WIDTH-1:0]                   cast_edata_in,
  input  logic                                       cast_res_valid,
  output logic                                       cast_res_ready,
  output logic [BLOCK_SIZE*OUT_MAN_WIDTH-1:0]        rsp_mdata_out,
  output logic [OUT_EXP_WIDTH-1:0]                   rsp_edata_out,
  output logic [NUM_REQ-1:0]                         rsp_valid,
  input  logic [NUM_REQ-1:0]                         rsp_ready,
  output logic                                       err_orphan
`ifdef MXINT_CAST_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0]                 grant_count
`endif
);

  localparam int TW     = idx_w(NUM_REQ);
  localparam int MBLK_W = BLOCK_SIZE * IN_MAN_WIDTH;

  logic [TW-1:0]           ptr_r;
  logic [NUM_REQ-1:0]      rot_s;
  logic                    found_s;
  logic [TW-1:0]           off_s;
  logic [TW:0]             sum_s;
  logic [TW-1:0]           grant_idx_s;
  logic [TW-1:0]           nxt_ptr_s;
  logic                    accept_s;
  logic [MBLK_W-1:0]       sel_mdata_s;
  logic [IN_EXP_WIDTH-1:0] sel_edata_s;
  logic                    cast_valid_r;
  logic [MBLK_W-1:0]       cast_mdata_r;
  logic [IN_EXP_WIDTH-1:0] cast_edata_r;
  logic                    err_orphan_r;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic [TW-1:0]           head_s;
  logic                    head_ready_s;
  logic                    pop_s;

  assign cast_valid     = cast_valid_r;
  assign cast_mdata_out = cast_mdata_r;
  assign cast_edata_out = cast_edata_r;
  assign err_orphan     = err_orphan_r;
  assign rsp_mdata_out  = cast_mdata_in;
  assign rsp_edata_out  = cast_edata_in;

  // A pop in the same cycle does not open a slot: only !full admits a new block.
  assign accept_s = found_s && rst && !fifo_full_s && (!cast_valid_r || cast_ready);
  assign cast_res_ready = !fifo_empty_s && head_ready_s;
  assign pop_s          = cast_res_valid && cast_res_ready;

  // Round-robin search: rotate so the priority holder lands at bit 0.
  always_comb begin
    rot_s   = NUM_REQ'({req_valid, req_valid} >> ptr_r);
    found_s = 1'b0;
    off_s   = {TW{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_s && rot_s[k]) begin
        found_s = 1'b1;
        off_s   = TW'(k);
      end else begin
        found_s = found_s;
        off_s   = off_s;
      end
    end
    sum_s = {1'b0, ptr_r} + {1'b0, off_s};
    if (sum_s >= (TW+1)'(NUM_REQ)) begin
      grant_idx_s = TW'(sum_s - (TW+1)'(NUM_REQ));
    end else begin
      grant_idx_s = sum_s[TW-1:0];
    end
    if (grant_idx_s == TW'(NUM_REQ-1)) begin
      nxt_ptr_s = {TW{1'b0}};
    end else begin
      nxt_ptr_s = grant_idx_s + TW'(1);
    end
  end

  // Select the granted block and drive the one-hot ready.
  always_comb begin
    sel_mdata_s = {MBLK_W{1'b0}};
    sel_edata_s = {IN_EXP_WIDTH{1'b0}};
    req_ready   = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_s == TW'(i)) begin
        sel_mdata_s = req_mdata_in[i*MBLK_W +: MBLK_W];
        sel_edata_s = req_edata_in[i*IN_EXP_WIDTH +: IN_EXP_WIDTH];
        req_ready[i] = accept_s;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Steer the returning result to the owner of the oldest outstanding tag.
  always_comb begin
    rsp_valid    = {NUM_REQ{1'b0}};
    head_ready_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (head_s == TW'(i)) begin
        rsp_valid[i] = cast_res_valid && !fifo_empty_s;
        head_ready_s = rsp_ready[i];
      end else begin
        rsp_valid[i] = 1'b0;
      end
    end
  end

  // Issue register and round-robin pointer; data held while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cast_valid_r <= 1'b0;
      cast_mdata_r <= {MBLK_W{1'b0}};
      cast_edata_r <= {IN_EXP_WIDTH{1'b0}};
      ptr_r        <= {TW{1'b0}};
    end else if (accept_s) begin
      cast_valid_r <= 1'b1;
      cast_mdata_r <= sel_mdata_s;
      cast_edata_r <= sel_edata_s;
      ptr_r        <= nxt_ptr_s;
    end else if (cast_ready) begin
      cast_valid_r <= 1'b0;
    end else begin
      cast_valid_r <= cast_valid_r;
    end
  end

  // Sticky flag for a result with no owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_orphan_r <= 1'b0;
    end else if (cast_res_valid && fifo_empty_s) begin
      err_orphan_r <= 1'b1;
    end else begin
      err_orphan_r <= err_orphan_r;
    end
  end

  mxint_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (TW)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept_s),
    .push_data (grant_idx_s),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (head_s)
  );

`ifdef MXINT_CAST_ARB_STATS_EN
  logic [STATS_W-1:0] grant_cnt_r [NUM_REQ];

  // Saturating per-requester accept counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt_r[i] <= {STATS_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept_s && (grant_idx_s == TW'(i))) begin
          grant_cnt_r[i] <= sat_inc(grant_cnt_r[i]);
        end else begin
          grant_cnt_r[i] <= grant_cnt_r[i];
        end
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    grant_count = {(NUM_REQ*STATS_W){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_count[i*STATS_W +: STATS_W] = grant_cnt_r[i];
    end
  end
`endif

endmodule

// File: doc/mxint_cast_arbiter.md
MXINT_CAST_ARBITER -- requirements
Module: mxint_cast_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters; minimum 2.
REQ-002 SHALL have parameter IN_MAN_WIDTH, default 8: input mantissa width.
REQ-003 SHALL have parameter IN_EXP_WIDTH, default 4: input exponent width.
REQ-004 SHALL have parameter OUT_MAN_WIDTH, default 8: result mantissa width.
REQ-005 SHALL have parameter OUT_EXP_WIDTH, default 4: result exponent width.
REQ-006 SHALL have parameter BLOCK_SIZE, default 4: mantissas per block.
REQ-007 SHALL have parameter MAX_OUTSTANDING, default 4: tag FIFO depth; power of two.
REQ-008 SHALL have clk, input, 1: the single clock.
REQ-009 SHALL have rst, input, 1: reset; asynchronous, active-low.
REQ-010 SHALL have req_mdata_in, input, NUM_REQ x BLOCK_SIZE x IN_MAN_WIDTH signed: requester mantissas.
REQ-011 SHALL have req_edata_in, input, NUM_REQ x IN_EXP_WIDTH: requester exponents.
REQ-012 SHALL have req_valid and req_ready, input and output, NUM_REQ each: per-requester handshake.
REQ-013 SHALL have cast_mdata_out, cast_edata_out, cast_valid, cast_ready (output, output, output, input): issue port to the shared cast datapath, same widths as the request port.
REQ-014 SHALL have cast_mdata_in, cast_edata_in, cast_res_valid, cast_res_ready (input, input, input, output): result port from the datapath, OUT_MAN_WIDTH and OUT_EXP_WIDTH.
REQ-015 SHALL have rsp_mdata_out and rsp_edata_out, output, OUT widths: shared result bus.
REQ-016 SHALL have rsp_valid and rsp_ready, output and input, NUM_REQ each: per-requester result handshake.
REQ-017 SHALL have err_orphan, output, 1: sticky flag for a result arriving with no tag outstanding.

Function
REQ-018 SHALL arbitrate round-robin per block: after a grant to i, priority order starts at (i+1) mod NUM_REQ.
REQ-019 SHALL assert at most one req_ready per cycle, only to the granted requester, and only when the issue register is empty or drains this cycle and tag count < MAX_OUTSTANDING.
  - A pop in the same cycle does not free a slot.
REQ-020 SHALL capture the accepted block into the issue register with 1-cycle latency: accept at cycle t, cast_valid=1 at t+1.
REQ-021 SHALL hold cast_* stable while cast_valid=1 and cast_ready=0.
REQ-022 SHALL push the granted index into the tag FIFO on accept.
REQ-023 SHALL route results combinationally: rsp_valid[head tag]=cast_res_valid; other rsp_valid bits 0; cast_res_ready=rsp_ready[head tag]; rsp_*data_out=cast_*data_in.
REQ-024 SHALL pop the tag FIFO on a cast_res_valid and cast_res_ready handshake.
REQ-025 SHALL, with tag FIFO empty and cast_res_valid=1, hold cast_res_ready=0 and set err_orphan until reset.
REQ-026 SHALL allow push and pop in the same cycle, leaving the count unchanged.
REQ-027 SHALL leave the round-robin pointer unchanged on cycles without an accept.

Reset
REQ-028 SHALL, on rst low, clear immediately: cast_valid=0, req_ready=0, rsp_valid=0, err_orphan=0, tag FIFO empty, round-robin pointer=0.
  - In-flight blocks and tags are discarded.
  - cast_mdata_out and cast_edata_out reset to 0.
REQ-029 SHALL resume arbitration on the first clk edge after rst deasserts.

Configuration
REQ-030 SHALL provide macro MXINT_CAST_ARB_STATS_EN.
  - Defined: adds output grant_count, NUM_REQ x 16; one counter per requester, increments per accept, saturates at 0xFFFF, resets to 0.
  - Undefined: no port and no counter logic; all other behaviour identical.

Structure
REQ-031 SHALL place the tag type (clog2(NUM_REQ) bits), the count width and the stats width constant in package mxint_cast_arb_pkg.
REQ-032 SHALL implement the tag FIFO as sub-module mxint_arb_tag_fifo (push, pop, full, empty, head).

Verification
REQ-033 Bench SHALL cover: all four requesters valid, cast_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; first cast_valid one cycle after first accept.
REQ-034 Bench SHALL cover: cast_ready=0 for 10 cycles with req 2 granted -> cast_* stable and all req_ready=0 after the issue register fills.
REQ-035 Bench SHALL cover: 4 blocks issued, no results returned (MAX_OUTSTANDING=4) -> req_ready stays 0; one result popped -> next accept exactly one cycle later.
REQ-036 Bench SHALL cover: results returned for tags 3,1 with rsp_ready[3]=0 for 5 cycles -> cast_res_ready=0 for those 5 cycles, then delivery to 3, then to 1.
REQ-037 Bench SHALL cover: cast_res_valid=1 with tag FIFO empty -> err_orphan=1 next cycle and stays 1; cleared only by rst.
REQ-038 Bench SHALL cover: rst asserted mid-stall with 2 tags outstanding -> all valids 0 immediately; after release, first grant goes to requester 0.
